// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   fetch_state_e : fetch FSM states (S_RESET, S_FETCH, S_FULL)
//   NOP_INSTR     : instruction presented when nothing is valid
//   IM_AW_DEFAULT : default instruction-memory word-address width
//   PC_STEP       : byte increment between sequential fetches
package mips_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam int unsigned IM_AW_DEFAULT = 5;
  localparam logic [31:0] PC_STEP       = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry 64-bit synchronous FIFO holding {pc, instr} pairs.
//   clk, rst  : clock, synchronous active-high reset
//   i_clear   : drop all entries (wins over push/pop)
//   i_push    : write i_wdata at the tail
//   i_pop     : consume the head
//   i_wdata   : entry to push
//   o_count   : occupancy, 0..DEPTH
//   o_head    : entry at the head (meaningful when o_count != 0)
module fetch_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [63:0]              i_wdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [63:0]              o_head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (!rst && !i_clear && i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage with a small prefetch queue ahead of IF/ID.
// Owns the fetch PC, drives the combinational IM, buffers fetched
// {pc, instr} pairs so downstream stalls do not waste IM cycles, and
// flushes/refetches on a redirect from ID.
//   clk, rst     : clock, synchronous active-high reset
//   im_addr      : IM word address (fetch_pc[IM_AW+1:2])
//   im_rdata     : IM instruction for im_addr, same cycle
//   stall        : downstream cannot accept this cycle
//   redirect     : flush the queue and restart at redirect_pc
//   redirect_pc  : redirect target (low two bits forced to 0)
//   if_valid     : if_pc/if_instr carry a real instruction
//   if_pc        : PC of the presented instruction (0 when invalid)
//   if_instr     : presented instruction (NOP when invalid)
//   q_count      : queue occupancy
// Build option: FETCH_BYPASS_EN presents im_rdata directly while the queue
// is empty, removing the bubble after reset or a redirect.
module fetch_queue_unit
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned IM_AW    = IM_AW_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [IM_AW-1:0]       im_addr,
  input  logic [31:0]            im_rdata,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   if_valid,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_instr,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_nxt;
  logic [31:0]   w_redirect_tgt;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_nxt;
  logic [63:0]   w_head;
  logic          w_q_nonempty;
  logic          w_bypass;
  logic          w_pop;
  logic          w_fifo_pop;
  logic          w_advance;
  logic          w_push;

  assign w_redirect_tgt = redirect_pc & ~32'h0000_0003;
  assign im_addr        = r_fetch_pc[IM_AW+1:2];
  assign w_q_nonempty   = (w_count != '0);
  assign q_count        = w_count;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = (r_state == S_FETCH) && !w_q_nonempty;
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    if_valid = w_q_nonempty | w_bypass;
    if_pc    = '0;
    if_instr = NOP_INSTR;
    if (w_q_nonempty) begin
      {if_pc, if_instr} = w_head;
    end else if (w_bypass) begin
      if_pc    = r_fetch_pc;
      if_instr = im_rdata;
    end
  end

  // A bypassed instruction that is consumed still advances the PC but is
  // never written into the queue, and the queue itself is not popped.
  always_comb begin
    w_pop      = if_valid & ~stall & ~redirect;
    w_fifo_pop = w_pop & w_q_nonempty;
    w_advance  = (r_state != S_RESET) & ~redirect &
                 ((w_count < CW'(DEPTH)) | w_pop);
    w_push     = w_advance & ~(w_bypass & w_pop);
  end

  always_comb begin
    w_count_nxt    = w_count + CW'(w_push) - CW'(w_fifo_pop);
    w_fetch_pc_nxt = r_fetch_pc;
    w_state_nxt    = r_state;
    if (redirect) begin
      w_count_nxt    = '0;
      w_fetch_pc_nxt = w_redirect_tgt;
      w_state_nxt    = S_FETCH;
    end else begin
      if (w_advance) w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
      case (r_state)
        S_RESET: w_state_nxt = S_FETCH;
        S_FETCH: if (stall && (w_count_nxt == CW'(DEPTH))) w_state_nxt = S_FULL;
        S_FULL:  if (w_pop) w_state_nxt = S_FETCH;
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RESET;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (redirect),
    .i_push  (w_push),
    .i_pop   (w_fifo_pop),
    .i_wdata ({r_fetch_pc, im_rdata}),
    .o_count (w_count),
    .o_head  (w_head)
  );

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

  localparam int unsigned TB_DEPTH = 2;
  localparam int unsigned TB_AW    = 5;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam int LAT = 1 - BYP;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [TB_AW-1:0]            im_addr;
  logic [31:0]                 im_rdata;
  logic                        stall = 1'b0;
  logic                        redirect = 1'b0;
  logic [31:0]                 redirect_pc = '0;
  logic                        if_valid;
  logic [31:0]                 if_pc;
  logic [31:0]                 if_instr;
  logic [$clog2(TB_DEPTH):0]   q_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // IM contents: word n holds 0x2000_0000 | n.
  always_comb im_rdata = 32'h2000_0000 | 32'(im_addr);

  fetch_queue_unit #(
    .DEPTH    (TB_DEPTH),
    .IM_AW    (TB_AW),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .im_addr     (im_addr),
    .im_rdata    (im_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .q_count     (q_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] imw(input logic [31:0] pc);
    return 32'h2000_0000 | ((pc >> 2) & ((32'd1 << TB_AW) - 32'd1));
  endfunction

  // Reference model: a queue of {pc, instr}, the fetch PC and a flag for
  // the quiet cycle that follows reset.
  logic [63:0] mq[$];
  logic [31:0] m_pc    = '0;
  bit          m_quiet = 1'b0;
  bit          m_known = 1'b0;

  always @(negedge clk) begin
    int          cnt;
    bit          byp, ev, pop, room;
    logic [31:0] epc, eins;
    cnt  = mq.size();
    byp  = (BYP == 1) && !m_quiet && (cnt == 0);
    ev   = (cnt != 0) || byp;
    epc  = (cnt != 0) ? mq[0][63:32] : (byp ? m_pc : 32'h0);
    eins = (cnt != 0) ? mq[0][31:0]  : (byp ? imw(m_pc) : 32'h0);
    if (m_known) begin
      chk("if_valid", 32'(if_valid), 32'(ev));
      chk("q_count",  32'(q_count),  32'(cnt));
      chk("if_pc",    if_pc,         epc);
      chk("if_instr", if_instr,      eins);
      chk("im_addr",  32'(im_addr),  (m_pc >> 2) & ((32'd1 << TB_AW) - 32'd1));
    end
    pop = ev && !stall && !redirect;
    if (rst) begin
      mq.delete();
      m_pc    = 32'h0;
      m_quiet = 1'b1;
      m_known = 1'b1;
    end else if (m_known) begin
      if (redirect) begin
        mq.delete();
        m_pc    = {redirect_pc[31:2], 2'b00};
        m_quiet = 1'b0;
      end else if (m_quiet) begin
        m_quiet = 1'b0;
      end else begin
        room = (cnt < TB_DEPTH) || pop;
        if (pop && cnt != 0) void'(mq.pop_front());
        if (room) begin
          if (!(byp && pop)) mq.push_back({m_pc, imw(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit s, input bit rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    @(negedge clk);
  endtask

  initial begin
    cyc(1, 0, 0, 32'h0);
    cyc(1, 0, 0, 32'h0);
    // Quiet cycle after reset.
    cyc(0, 0, 0, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_count", 32'(q_count), 32'h0);
    chk("rst_pc",    if_pc,        32'h0);
    chk("rst_instr", if_instr,     32'h0);
    repeat (LAT) cyc(0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);
    chk("run_pc0", if_pc, 32'h0);
    chk("run_i0",  if_instr, 32'h2000_0000);
    cyc(0, 0, 0, 32'h0);
    chk("run_pc4", if_pc, 32'h4);
    chk("run_i1",  if_instr, 32'h2000_0001);
    // Stall for six cycles starting with pc 8 presented.
    cyc(0, 1, 0, 32'h0);
    chk("stall_pc8", if_pc, 32'h8);
    repeat (5) cyc(0, 1, 0, 32'h0);
    chk("full_count", 32'(q_count), 32'h2);
    chk("full_imaddr", 32'(im_addr), 32'h4);
    chk("full_pc", if_pc, 32'h8);
    cyc(0, 0, 0, 32'h0);
    chk("rel_pc8", if_pc, 32'h8);
    cyc(0, 0, 0, 32'h0);
    chk("rel_pcC", if_pc, 32'hC);
    cyc(0, 0, 0, 32'h0);
    chk("rel_pc10", if_pc, 32'h10);
    chk("rel_i4", if_instr, 32'h2000_0004);
    // Redirect with a full, stalled queue.
    repeat (3) cyc(0, 1, 0, 32'h0);
    chk("pre_redir_count", 32'(q_count), 32'h2);
    cyc(0, 1, 1, 32'h0000_0043);
    cyc(0, 0, 0, 32'h0);
    chk("redir_count", 32'(q_count), 32'h0);
    chk("redir_valid", 32'(if_valid), 32'(BYP));
    if (LAT == 1) cyc(0, 0, 0, 32'h0);
    chk("redir_pc", if_pc, 32'h40);
    chk("redir_i", if_instr, 32'h2000_0010);
    // PC wrap-around.
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 32'h0);
    chk("wrap_imaddr", 32'(im_addr), 32'd31);
    if (LAT == 1) cyc(0, 0, 0, 32'h0);
    chk("wrap_pc_hi", if_pc, 32'hFFFF_FFFC);
    chk("wrap_i_hi", if_instr, 32'h2000_001F);
    cyc(0, 0, 0, 32'h0);
    chk("wrap_pc_lo", if_pc, 32'h0);
    chk("wrap_i_lo", if_instr, 32'h2000_0000);
    // Reset wins over a simultaneous redirect and stall.
    repeat (3) cyc(0, 1, 0, 32'h0);
    cyc(1, 1, 1, 32'h0000_0100);
    cyc(0, 0, 0, 32'h0);
    chk("rr_valid", 32'(if_valid), 32'h0);
    chk("rr_count", 32'(q_count), 32'h0);
    chk("rr_imaddr", 32'(im_addr), 32'h0);
    repeat (LAT + 1) cyc(0, 0, 0, 32'h0);
    chk("rr_pc", if_pc, 32'h0);
    chk("rr_v1", 32'(if_valid), 32'h1);
    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 9) < 4),
          ($urandom_range(0, 19) == 0),
          tgt);
    end
    repeat (4) cyc(0, 0, 0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives the combinational instruction memory (word address = PC[IM_AW+1:2]).
- Buffers fetched {PC, instruction} pairs in a small prefetch queue, so a stall from the hazard unit does not waste IM cycles.
- Accepts redirects from branch or jump resolution in ID; a redirect flushes the queue and restarts fetch at the target.

Parameters:
DEPTH, 2, prefetch queue entries (power of two, 2..8)
IM_AW, 5, instruction-memory word-address width
RESET_PC, 32'h0000_0000, fetch PC after reset (word aligned)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
im_addr  out  IM_AW  word address to IM = fetch_pc[IM_AW+1:2]
im_rdata  in  32  IM instruction, valid in the same cycle as im_addr
stall  in  1  downstream cannot accept (IF/ID write disable)
redirect  in  1  branch taken or jump; flush and refetch
redirect_pc  in  32  target PC; bits [1:0] ignored and forced 0
if_valid  out  1  if_pc/if_instr hold a real instruction
if_pc  out  32  PC of the presented instruction
if_instr  out  32  presented instruction; 32'h0 (NOP) when !if_valid
q_count  out  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc <= RESET_PC; queue emptied; state <= S_RESET.
  - Outputs: if_valid=0, if_pc=0, if_instr=0, q_count=0.
  - rst has priority over every other input, including reset asserted mid-redirect or mid-stall.
- States:
  - S_RESET: no push, no pop. Next state is S_FETCH unconditionally; this is a one-cycle quiet period after reset.
  - S_FETCH: push {fetch_pc, im_rdata} whenever push is allowed, then fetch_pc <= fetch_pc+4. Goes to S_FULL when the queue becomes full and stall=1.
  - S_FULL: queue full; fetch_pc frozen; im_addr held. Goes to S_FETCH on the first cycle with pop=1 or redirect=1.
- pop = if_valid & ~stall & ~redirect. The head is consumed at the clock edge.
- push allowed = state!=S_RESET & ~redirect & (count<DEPTH | pop). Push and pop in the same cycle leave count unchanged.
- Presentation: if_valid = (count!=0). if_pc and if_instr show the queue head when valid, and 0 otherwise.
- Latency: an instruction pushed at edge N is presentable from cycle N+1. With an empty queue and no stall, one instruction is presented per cycle at steady state.
- Redirect:
  - The queue is cleared and fetch_pc <= {redirect_pc[31:2],2'b00}.
  - The current head is discarded, not popped.
  - Redirect wins over stall and over a full queue.
  - if_valid is 0 in the cycle after the redirect (one bubble) unless FETCH_BYPASS_EN is defined.
- Wrap-around:
  - fetch_pc wraps modulo 2^32.
  - im_addr truncates naturally, so the IM aliases every 2^(IM_AW+2) bytes. No error is flagged.
- Queue pointers wrap modulo DEPTH. Count never exceeds DEPTH and never underflows; a pop with count=0 is impossible by construction.
- A stall held indefinitely freezes all state once the queue is full.
- Redirect asserted while in S_RESET: fetch_pc is loaded with the target, and S_FETCH follows.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined:
  - When count==0 and state==S_FETCH, im_rdata/fetch_pc are presented combinationally with if_valid=1.
  - If that bypassed instruction is popped (~stall), it is not pushed, and fetch_pc still advances.
  - If stall=1, it is pushed normally.
  - Result: zero bubbles after a redirect or reset.
- Undefined: outputs come strictly from the queue (registered path, one bubble after a redirect).

Decomposition:
- Shared package mips_pkg holds:
  - the state enum (S_RESET, S_FETCH, S_FULL);
  - NOP_INSTR = 32'h0;
  - the default IM_AW;
  - PC_STEP = 4.
- One natural sub-module, fetch_fifo: a DEPTH-entry 64-bit synchronous FIFO with clear, push, pop, count, head outputs, and sync active-high reset. The FSM, PC logic and bypass stay in the top.

Test Plan:
- Reset then free-run, IM word n = 32'h2000_0000|n, stall=0: cycle after S_RESET shows nothing; then if_pc 0,4,8,... with if_instr 0x20000000, 0x20000001, ... one per cycle; q_count ≤1.
- Hold stall=1 for 6 cycles from pc=8: q_count rises to 2 then stays; state S_FULL; im_addr frozen at 4 (pc 0x10). Release stall: if_pc 8, C, 10 in consecutive cycles with no skip or duplicate.
- redirect=1, redirect_pc=32'h0000_0043 while the queue is full and stall=1: next cycle q_count=0 and if_valid=0 (bypass off); following cycle if_pc=32'h40, if_instr = IM word 16.
- Same redirect with FETCH_BYPASS_EN defined: next cycle if_valid=1, if_pc=32'h40, with no bubble.
- fetch_pc near 32'hFFFF_FFFC, stall=0: if_pc FFFF_FFFC then 0000_0000; im_addr 31 then 0.
- rst asserted in a cycle with redirect=1 and stall=1: next cycle if_valid=0, q_count=0, fetch_pc=RESET_PC; the redirect target is ignored.
